branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Multi-cycle branch resolution controller for the core's PC path. It accepts one decoded control-transfer request at a time, evaluates the RV32I conditional-branch condition selected by `funct3` on registered operands, and computes the taken target and the fall-through address. It then publishes the next PC with a one-cycle strobe and holds a pipeline flush for a fixed number of cycles after a taken branch. It sits between decode/register-read and the PC register/fetch stage.

## Interface
- `XLEN`, 32: data and address width.
- `FLUSH_CYCLES`, 2: flush duration after a taken branch. Legal range 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block can accept a request.
- `branch`  in  1  the request is a conditional branch. 0 means a sequential instruction.
- `funct3`  in  3  branch type.
- `pc`  in  XLEN  address of the requesting instruction.
- `imm`  in  XLEN  sign-extended byte offset.
- `rs1_data`, `rs2_data`  in  XLEN  compare operands.
- `pc_out`  out  XLEN  next PC, qualified by `pc_valid`.
- `pc_valid`  out  1  one-cycle strobe carrying the result.
- `taken`  out  1  the branch is taken; qualified by `pc_valid`.
- `illegal`  out  1  one-cycle strobe, coincident with `pc_valid`.
- `flush`  out  1  squash the younger pipeline stages.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, EVAL, RESOLVE, FLUSH.
- **IDLE:**
  - `req_ready` = 1 and `busy` = 0.
  - On `req_valid && req_ready`, register `branch`, `funct3`, `pc`, `imm`, `rs1_data` and `rs2_data`, then go to EVAL.
  - Inputs are ignored in every other state.
- **EVAL:** compute the condition from the registered operands.
  - 000 equal; 001 not equal.
  - 100 signed less-than; 101 signed greater-or-equal.
  - 110 unsigned less-than; 111 unsigned greater-or-equal.
  - 010 and 011 are illegal: condition forced to 0 and the illegal flag is set.
  - `target` = `pc` + `imm`, and `fallthrough` = `pc` + 4. Both are computed modulo 2^XLEN; wrap-around is silent.
  - A taken target with `target[1:0]` != 0 is misaligned. It sets the illegal flag and forces not-taken.
  - `branch` = 0 gives not-taken, not illegal, regardless of `funct3`.
  - Register the result and go to RESOLVE.
- **RESOLVE:**
  - Assert `pc_valid` = 1 for exactly this cycle, together with `pc_out`, `taken` and `illegal`.
  - `pc_out` = `target` if taken, else `fallthrough`.
  - If taken and FLUSH_CYCLES > 0, go to FLUSH; otherwise go to IDLE.
- **FLUSH:** `flush` = 1 for exactly FLUSH_CYCLES consecutive cycles, counted by a 4-bit down-counter. Then go to IDLE.
- **Output values:**
  - `busy` = 1 in EVAL, RESOLVE and FLUSH.
  - `req_ready` = (state == IDLE) && !`reset`.
  - `pc_out`, `taken` and `illegal` are 0 whenever `pc_valid` = 0.

## Timing
- **Reset:**
  - While `reset` = 1, at the next edge: state becomes IDLE and the flush counter is cleared.
  - `pc_valid`, `taken`, `illegal`, `flush` and `busy` are 0, and `pc_out` = 0.
  - `req_ready` is 0 in a reset cycle and 1 in the first cycle after reset is deasserted.
- **Reset mid-operation:**
  - Aborts the request in any state. No `pc_valid` strobe is produced.
  - `flush` drops at the next edge.
- **Latency:** a request accepted at edge E gives EVAL in cycle E+1 and `pc_valid` in cycle E+2.
- **Flush timing:** for a taken branch, `flush` is high in cycles E+3 .. E+2+FLUSH_CYCLES.
- **Throughput:**
  - Not-taken or illegal: one request per 3 cycles.
  - Taken: one request per 3+FLUSH_CYCLES cycles.
- `req_ready` rises in the same cycle the FSM re-enters IDLE. A request held valid is accepted on that edge.
- `req_valid` deasserted in IDLE has no effect; there is no timeout.
- Operand changes after acceptance have no effect.

## Configuration
- **`BRANCH_STATS_EN` defined:**
  - Adds outputs `taken_count` and `not_taken_count`, each 32 bits, reset to 0.
  - On each `pc_valid` with a registered `branch` = 1 and no illegal flag, increment the matching counter.
  - Counters saturate at 0xFFFF_FFFF.
  - Sequential and illegal requests are not counted.
- **`BRANCH_STATS_EN` undefined:** the ports and the counters are absent. All other behaviour is identical.

## Test plan
- Reset, then `branch`=1, `funct3`=000, `pc`=0x100, `imm`=0x20, `rs1`=`rs2`=5 accepted at edge E:
  - `pc_valid` at E+2 with `pc_out`=0x120, `taken`=1.
  - `flush` high for E+3..E+4; `req_ready` returns at E+5.
- BNE with equal operands (`pc`=0x200): `pc_out`=0x204, `taken`=0, `flush` never asserted, `req_ready` back at E+3.
- BLT with `rs1`=0xFFFF_FFFF and `rs2`=1 gives taken. BLTU with the same operands gives not-taken.
- Illegal and misaligned cases:
  - `funct3`=010: `illegal`=1, `taken`=0, `pc_out`=`pc`+4.
  - Taken BEQ with `imm`=0x2: `illegal`=1, `pc_out`=`pc`+4.
- Wrap-around and sequential cases:
  - `pc`=0xFFFF_FFFC with `branch`=0: `pc_out`=0x0000_0000.
  - Taken branch with `pc`=0x10, `imm`=-0x20: `pc_out`=0xFFFF_FFF0.
- Reset asserted in the FLUSH cycle: `flush`=0 the next cycle, no further `pc_valid`, and `req_ready`=1 the cycle after reset drops. With `BRANCH_STATS_EN` defined, the counters read 0.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Request/result bundle between decode/register-read and the branch sequencer.
// master drives requests and consumes results; slave is the sequencer.
interface branch_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            branch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            taken;
  logic            illegal;
  logic            flush;
  logic            busy;

  modport master (
    output req_valid, branch, funct3, pc, imm, rs1_data, rs2_data,
    input  req_ready, pc_out, pc_valid, taken, illegal, flush, busy
  );

  modport slave (
    input  req_valid, branch, funct3, pc, imm, rs1_data, rs2_data,
    output req_ready, pc_out, pc_valid, taken, illegal, flush, busy
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle RV32I conditional-branch resolver: IDLE -> EVAL -> RESOLVE [-> FLUSH].
// Optional taken/not-taken statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  branch_sequencer_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         taken_count,
  output logic [31:0]         not_taken_count
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state, state_nxt;
  logic [3:0]      flush_cnt;

  logic            r_branch;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_pc, r_imm, r_rs1, r_rs2;

  logic            res_taken, res_illegal;
  logic [XLEN-1:0] res_pc;

  logic            cond, f3_illegal, misaligned, eval_taken, eval_illegal;
  logic [XLEN-1:0] target, fallthrough;

  // State register and flush down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESOLVE && state_nxt == FLUSH)
        flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH)
        flush_cnt <= flush_cnt - 4'd1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = EVAL;
      EVAL:    state_nxt = RESOLVE;
      RESOLVE: state_nxt = (res_taken && FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:   if (flush_cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand/result registers carry no reset; they are only observed after being loaded.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      r_branch <= bus.branch;
      r_funct3 <= bus.funct3;
      r_pc     <= bus.pc;
      r_imm    <= bus.imm;
      r_rs1    <= bus.rs1_data;
      r_rs2    <= bus.rs2_data;
    end
    if (state == EVAL) begin
      res_taken   <= eval_taken;
      res_illegal <= eval_illegal;
      res_pc      <= eval_taken ? target : fallthrough;
    end
  end

  // Condition evaluation on the registered operands
  always_comb begin
    cond       = 1'b0;
    f3_illegal = 1'b0;
    unique case (r_funct3)
      3'b000:  cond = (r_rs1 == r_rs2);
      3'b001:  cond = (r_rs1 != r_rs2);
      3'b100:  cond = ($signed(r_rs1) <  $signed(r_rs2));
      3'b101:  cond = ($signed(r_rs1) >= $signed(r_rs2));
      3'b110:  cond = (r_rs1 <  r_rs2);
      3'b111:  cond = (r_rs1 >= r_rs2);
      default: f3_illegal = 1'b1;
    endcase
  end

  assign target       = r_pc + r_imm;
  assign fallthrough  = r_pc + XLEN'(4);
  assign misaligned   = r_branch && cond && (target[1:0] != 2'b00);
  assign eval_illegal = r_branch && (f3_illegal || misaligned);
  assign eval_taken   = r_branch && cond && !eval_illegal;

  // Outputs: result fields are zero outside the RESOLVE strobe
  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.busy      = (state != IDLE);
  assign bus.pc_valid  = (state == RESOLVE);
  assign bus.pc_out    = bus.pc_valid ? res_pc : '0;
  assign bus.taken     = bus.pc_valid && res_taken;
  assign bus.illegal   = bus.pc_valid && res_illegal;
  assign bus.flush     = (state == FLUSH);

`ifdef BRANCH_STATS_EN
  // Saturating counters over legal conditional branches only
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count     <= '0;
      not_taken_count <= '0;
    end else if (state == RESOLVE && r_branch && !res_illegal) begin
      if (res_taken) begin
        if (taken_count != 32'hFFFF_FFFF) taken_count <= taken_count + 32'd1;
      end else begin
        if (not_taken_count != 32'hFFFF_FFFF) not_taken_count <= not_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed-vector bench for branch_sequencer: latency, flush length, edge cases, reset abort.
module tb_branch_sequencer;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_bad    = 0;

  branch_sequencer_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count, not_taken_count;
`endif

  branch_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request at the current negedge, return at the EVAL-cycle negedge
  // with operands scrambled to show that post-acceptance changes are ignored.
  task automatic send(input logic br, input logic [2:0] f3, input logic [31:0] p,
                      input logic [31:0] im, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.branch    = br;
    bus.funct3    = f3;
    bus.pc        = p;
    bus.imm       = im;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.branch    = ~br;
    bus.funct3    = ~f3;
    bus.pc        = ~p;
    bus.imm       = ~im;
    bus.rs1_data  = ~a;
    bus.rs2_data  = b + 32'd7;
  endtask

  task automatic run(input string tag, input logic br, input logic [2:0] f3,
                     input logic [31:0] p, input logic [31:0] im,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_pc, input logic exp_taken, input logic exp_ill);
    int cycles;
    int nflush;
    check({tag, "_ready"}, bus.req_ready, 1);
    send(br, f3, p, im, a, b);
    check({tag, "_eval"}, {bus.busy, bus.pc_valid, bus.req_ready}, 3'b100);
    @(negedge clk);
    check({tag, "_valid"}, bus.pc_valid, 1);
    check({tag, "_pc"}, bus.pc_out, exp_pc);
    check({tag, "_taken_ill"}, {bus.taken, bus.illegal}, {exp_taken, exp_ill});
    cycles = 0;
    nflush = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.req_ready) break;
      if (bus.flush) nflush++;
    end
    check({tag, "_flushlen"}, nflush, exp_taken ? FC : 0);
    check({tag, "_return"}, cycles, exp_taken ? FC + 1 : 1);
  endtask

  initial begin
    int seen_valid;
    bus.req_valid = 1'b0;
    bus.branch    = 1'b0;
    bus.funct3    = 3'b000;
    bus.pc        = '0;
    bus.imm       = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outs", {bus.pc_valid, bus.taken, bus.illegal, bus.flush, bus.busy, bus.req_ready}, 6'b0);
    check("rst_pc", bus.pc_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //  tag     br f3      pc            imm           rs1           rs2           exp_pc        tk ill
    run("beq",  1, 3'b000, 32'h100,      32'h20,       32'd5,        32'd5,        32'h120,      1, 0);
    run("bne",  1, 3'b001, 32'h200,      32'h40,       32'd5,        32'd5,        32'h204,      0, 0);
    run("blt",  1, 3'b100, 32'h300,      32'h10,       32'hFFFF_FFFF, 32'd1,       32'h310,      1, 0);
    run("bltu", 1, 3'b110, 32'h300,      32'h10,       32'hFFFF_FFFF, 32'd1,       32'h304,      0, 0);
    run("f010", 1, 3'b010, 32'h400,      32'h8,        32'd0,        32'd0,        32'h404,      0, 1);
    run("mis",  1, 3'b000, 32'h500,      32'h2,        32'd9,        32'd9,        32'h504,      0, 1);
    run("seqw", 0, 3'b000, 32'hFFFF_FFFC, 32'h40,      32'd1,        32'd1,        32'h0,        0, 0);
    run("bwrap",1, 3'b000, 32'h10,       32'hFFFF_FFE0, 32'd3,       32'd3,        32'hFFFF_FFF0, 1, 0);
    run("bge",  1, 3'b101, 32'h600,      32'h100,      32'd1,        32'hFFFF_FFFF, 32'h700,     1, 0);
    run("bgeu", 1, 3'b111, 32'h600,      32'h100,      32'd1,        32'hFFFF_FFFF, 32'h604,     0, 0);
    run("seqf", 0, 3'b010, 32'h700,      32'h100,      32'd0,        32'd0,        32'h704,      0, 0);

`ifdef BRANCH_STATS_EN
    check("cnt_taken", taken_count, 32'd4);
    check("cnt_not_taken", not_taken_count, 32'd3);
`endif

    // Reset asserted during the first FLUSH cycle
    send(1'b1, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    @(negedge clk);
    check("ra_valid", bus.pc_valid, 1);
    @(negedge clk);
    check("ra_inflush", bus.flush, 1);
    reset = 1'b1;
    @(negedge clk);
    check("ra_flush_drop", {bus.flush, bus.busy, bus.pc_valid, bus.req_ready}, 4'b0);
    reset = 1'b0;
    @(negedge clk);
    check("ra_ready", bus.req_ready, 1);
`ifdef BRANCH_STATS_EN
    check("ra_cnt", {taken_count, not_taken_count}, 64'h0);
`endif
    seen_valid = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.pc_valid || bus.flush || bus.busy) seen_valid++;
    end
    check("ra_quiet", seen_valid, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
